// File: rtl/deque_arbiter_if.sv
// Command/response and deque-bus bundle for deque_arbiter.
//
// Requester A/B command channels (valid/ready), the single response channel
// and the shared deque bus with both deques' status and read ports.
//   slave  : the arbiter's view (takes commands, drives response and deque bus)
//   master : the environment's view (requesters, response sink, the deques)
interface deque_arbiter_if;
  logic       a_valid;
  logic       a_ready;
  logic [1:0] a_op;
  logic       a_deque;
  logic       a_end;
  logic [7:0] a_data;

  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_op;
  logic       b_deque;
  logic       b_end;
  logic [7:0] b_data;

  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_err;

  logic       dq_select;
  logic       dq_end;
  logic       dq_push;
  logic       dq_pop;
  logic [7:0] dq_data_in;

  logic       dq0_empty;
  logic       dq0_full;
  logic       dq1_empty;
  logic       dq1_full;
  logic [7:0] dq0_data_out;
  logic [7:0] dq1_data_out;

  modport slave (
    input  a_valid, a_op, a_deque, a_end, a_data,
    input  b_valid, b_op, b_deque, b_end, b_data,
    output a_ready, b_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output dq_select, dq_end, dq_push, dq_pop, dq_data_in,
    input  dq0_empty, dq0_full, dq1_empty, dq1_full, dq0_data_out, dq1_data_out
  );

  modport master (
    output a_valid, a_op, a_deque, a_end, a_data,
    output b_valid, b_op, b_deque, b_end, b_data,
    input  a_ready, b_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  dq_select, dq_end, dq_push, dq_pop, dq_data_in,
    output dq0_empty, dq0_full, dq1_empty, dq1_full, dq0_data_out, dq1_data_out
  );
endinterface

// File: rtl/deque_arbiter.sv
// Two-requester round-robin command arbiter and sequencer for the dual
// 8-bit deque datapath. One command is in flight at a time and walks
// IDLE -> SEL -> EXEC -> RESP, producing exactly one response.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    deque_arbiter_if.slave: A/B command handshakes (a_ready/b_ready
//          are the only outputs combinational on inputs), response strobe,
//          shared deque select/end/push/pop/data bus and deque status/read ports.
module deque_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  deque_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_PEEK    = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  // Decide the outcome of a command from the target deque status.
  // Returns {err, push, pop}; an erroring command never strobes the deque.
  function automatic logic [2:0] plan_strobes(input logic [1:0] op,
                                              input logic       empty,
                                              input logic       full);
    logic [2:0] plan;
    plan = 3'b000;
    case (op)
      OP_PEEK:    plan = {empty, 1'b0, 1'b0};
      OP_PUSH:    plan = {full, ~full, 1'b0};
      OP_POP:     plan = {empty, 1'b0, ~empty};
      OP_REPLACE: plan = {empty, ~empty, ~empty};
      default:    plan = 3'b000;
    endcase
    return plan;
  endfunction

  state_t     state_r;
  logic       last_grant_r;
  logic [1:0] cmd_op_r;
  logic       cmd_deque_r;
  logic       cmd_end_r;
  logic       cmd_id_r;
  logic [7:0] cmd_data_r;
  logic       cmd_err_r;

  logic       dq_select_r;
  logic       dq_end_r;
  logic       dq_push_r;
  logic       dq_pop_r;
  logic [7:0] dq_data_in_r;

  logic       rsp_valid_r;
  logic       rsp_id_r;
  logic [7:0] rsp_data_r;
  logic       rsp_err_r;

  logic       grant_a_s;
  logic       grant_b_s;
  logic [1:0] win_op_s;
  logic       win_deque_s;
  logic       win_end_s;
  logic [7:0] win_data_s;

  logic       sel_empty_s;
  logic       sel_full_s;
  logic [7:0] sel_top_s;
  logic [2:0] plan_s;

  // Round-robin grant: only in IDLE and out of reset; on a tie the requester
  // not granted last wins (last_grant_r = 1 means B was last, so A wins).
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (rst_n && (state_r == ST_IDLE)) begin
      if (bus.a_valid && bus.b_valid) begin
        if (last_grant_r) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else begin
        grant_a_s = bus.a_valid;
        grant_b_s = bus.b_valid;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Mux the winning requester's command fields for latching.
  always_comb begin
    win_op_s    = bus.a_op;
    win_deque_s = bus.a_deque;
    win_end_s   = bus.a_end;
    win_data_s  = bus.a_data;
    if (grant_b_s) begin
      win_op_s    = bus.b_op;
      win_deque_s = bus.b_deque;
      win_end_s   = bus.b_end;
      win_data_s  = bus.b_data;
    end else begin
      win_op_s    = bus.a_op;
      win_deque_s = bus.a_deque;
      win_end_s   = bus.a_end;
      win_data_s  = bus.a_data;
    end
  end

  // Pick status and read port of the deque addressed by the latched command.
  always_comb begin
    sel_empty_s = bus.dq0_empty;
    sel_full_s  = bus.dq0_full;
    sel_top_s   = bus.dq0_data_out;
    if (cmd_deque_r) begin
      sel_empty_s = bus.dq1_empty;
      sel_full_s  = bus.dq1_full;
      sel_top_s   = bus.dq1_data_out;
    end else begin
      sel_empty_s = bus.dq0_empty;
      sel_full_s  = bus.dq0_full;
      sel_top_s   = bus.dq0_data_out;
    end
  end

  assign plan_s = plan_strobes(cmd_op_r, sel_empty_s, sel_full_s);

  // Command sequencer with all bus/response outputs registered.
  // The push/pop strobes for EXEC are registered at the SEL edge from the
  // status seen in SEL: only this block mutates the deques and the previous
  // command's strobe has long settled, so that status equals the EXEC status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      cmd_op_r     <= 2'b00;
      cmd_deque_r  <= 1'b0;
      cmd_end_r    <= 1'b0;
      cmd_id_r     <= 1'b0;
      cmd_data_r   <= 8'h00;
      cmd_err_r    <= 1'b0;
      dq_select_r  <= 1'b0;
      dq_end_r     <= 1'b0;
      dq_push_r    <= 1'b0;
      dq_pop_r     <= 1'b0;
      dq_data_in_r <= 8'h00;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_data_r   <= 8'h00;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dq_push_r    <= 1'b0;
          dq_pop_r     <= 1'b0;
          dq_data_in_r <= 8'h00;
          rsp_valid_r  <= 1'b0;
          if (grant_a_s || grant_b_s) begin
            cmd_op_r     <= win_op_s;
            cmd_deque_r  <= win_deque_s;
            cmd_end_r    <= win_end_s;
            cmd_data_r   <= win_data_s;
            cmd_id_r     <= grant_b_s;
            last_grant_r <= grant_b_s;
            // select/end are presented during SEL so the deques capture them
            dq_select_r  <= win_deque_s;
            dq_end_r     <= win_end_s;
            state_r      <= ST_SEL;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_SEL: begin
          cmd_err_r    <= plan_s[2];
          dq_push_r    <= plan_s[1];
          dq_pop_r     <= plan_s[0];
          dq_data_in_r <= plan_s[1] ? cmd_data_r : 8'h00;
          rsp_valid_r  <= 1'b0;
          state_r      <= ST_EXEC;
        end
        ST_EXEC: begin
          dq_push_r    <= 1'b0;
          dq_pop_r     <= 1'b0;
          dq_data_in_r <= 8'h00;
          rsp_valid_r  <= 1'b1;
          rsp_id_r     <= cmd_id_r;
          rsp_err_r    <= cmd_err_r;
          // read port reflects the select captured at the SEL edge; PUSH
          // and rejected commands return zero
          rsp_data_r   <= (cmd_err_r || (cmd_op_r == OP_PUSH)) ? 8'h00 : sel_top_s;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          dq_push_r    <= 1'b0;
          dq_pop_r     <= 1'b0;
          dq_data_in_r <= 8'h00;
          rsp_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          dq_push_r    <= 1'b0;
          dq_pop_r     <= 1'b0;
          dq_data_in_r <= 8'h00;
          rsp_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a_ready    = grant_a_s;
  assign bus.b_ready    = grant_b_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.dq_select  = dq_select_r;
  assign bus.dq_end     = dq_end_r;
  // strobes are suppressed immediately while reset is asserted
  assign bus.dq_push    = dq_push_r & rst_n;
  assign bus.dq_pop     = dq_pop_r & rst_n;
  assign bus.dq_data_in = dq_data_in_r;

endmodule

// File: tb/tb_deque_arbiter.sv
// Self-checking bench for deque_arbiter: a pair of behavioural deques as the
// environment, a transaction-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_deque_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  deque_arbiter_if bus ();

  deque_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- environment deques (capacity 16) ----------------
  logic [7:0] ed0[$];
  logic [7:0] ed1[$];
  logic [7:0] eq[$];
  bit         env_sel = 1'b0;
  bit         env_end = 1'b0;
  logic       s_push, s_pop, s_sel, s_end;
  logic [7:0] s_data;

  function automatic logic [7:0] top_of(input bit back, input int n, input logic [7:0] f, input logic [7:0] b);
    if (n == 0) return 8'h00;
    return back ? b : f;
  endfunction

  task automatic env_drive();
    bus.dq0_empty    = (ed0.size() == 0);
    bus.dq0_full     = (ed0.size() == 16);
    bus.dq1_empty    = (ed1.size() == 0);
    bus.dq1_full     = (ed1.size() == 16);
    bus.dq0_data_out = (ed0.size() == 0) ? 8'h00 : (env_end ? ed0[ed0.size()-1] : ed0[0]);
    bus.dq1_data_out = (ed1.size() == 0) ? 8'h00 : (env_end ? ed1[ed1.size()-1] : ed1[0]);
  endtask

  initial begin
    env_drive();
    forever begin
      @(negedge clk); #1;
      s_push = bus.dq_push; s_pop = bus.dq_pop; s_data = bus.dq_data_in;
      s_sel = bus.dq_select; s_end = bus.dq_end;
      @(posedge clk); #1;
      if (env_sel) eq = ed1; else eq = ed0;
      if (s_push && s_pop) begin
        if (eq.size() > 0) begin
          if (env_end) eq[eq.size()-1] = s_data; else eq[0] = s_data;
        end
      end else if (s_push) begin
        if (eq.size() < 16) begin
          if (env_end) eq.push_back(s_data); else eq.push_front(s_data);
        end
      end else if (s_pop) begin
        if (eq.size() > 0) begin
          if (env_end) void'(eq.pop_back()); else void'(eq.pop_front());
        end
      end
      if (env_sel) ed1 = eq; else ed0 = eq;
      env_sel = s_sel;
      env_end = s_end;
      env_drive();
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];
  logic [7:0] mq[$];
  bit         started = 1'b0;
  bit         busy = 1'b0;
  int         cyc = 0;
  int         tacc = 0;
  int         ph;
  bit         ga, gb;
  bit [1:0]   c_op;
  bit         c_dq, c_en, c_who;
  bit [7:0]   c_data;
  bit         o_err, o_push, o_pop;
  bit [7:0]   o_data;
  bit         ep, eo;
  bit         lg = 1'b1;
  bit         e_sel = 1'b0, e_end = 1'b0, e_rid = 1'b0, e_rerr = 1'b0;
  bit [7:0]   e_rdata = 8'h00;

  int         rsp_cnt = 0;
  bit         lid[$];
  bit [7:0]   ldata[$];
  bit         lerr[$];
  int         lcyc[$];
  int         push_cnt = 0;
  int         both_cnt = 0;
  int         last_push_cyc = -1;
  int         last_acc_cyc = -1;
  bit [7:0]   last_push_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk); #1;
      ph = busy ? (cyc - tacc) : -1;
      ga = 1'b0; gb = 1'b0;
      if (rst_n && !busy) begin
        if (bus.a_valid && bus.b_valid) begin
          if (lg) ga = 1'b1; else gb = 1'b1;
        end else begin
          ga = bus.a_valid; gb = bus.b_valid;
        end
      end
      o_err = 1'b0; o_push = 1'b0; o_pop = 1'b0; o_data = 8'h00;
      if (ph == 2) begin
        if (c_dq) mq = rq1; else mq = rq0;
        case (c_op)
          2'b00: begin o_err = (mq.size() == 0); end
          2'b01: begin o_err = (mq.size() == 16); o_push = !o_err; end
          2'b10: begin o_err = (mq.size() == 0); o_pop = !o_err; end
          default: begin o_err = (mq.size() == 0); o_push = !o_err; o_pop = !o_err; end
        endcase
        if (!o_err && c_op != 2'b01)
          o_data = c_en ? mq[mq.size()-1] : mq[0];
      end
      ep = (ph == 2) && rst_n && o_push;
      eo = (ph == 2) && rst_n && o_pop;
      if (started) begin
        chk("a_ready", 32'(bus.a_ready), 32'(ga));
        chk("b_ready", 32'(bus.b_ready), 32'(gb));
        chk("dq_push", 32'(bus.dq_push), 32'(ep));
        chk("dq_pop", 32'(bus.dq_pop), 32'(eo));
        chk("dq_select", 32'(bus.dq_select), 32'(e_sel));
        chk("dq_end", 32'(bus.dq_end), 32'(e_end));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ph == 3));
        chk("rsp_id", 32'(bus.rsp_id), 32'(e_rid));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e_rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_rerr));
        if (ph == 2) begin
          if (ep) chk("dq_data_in", 32'(bus.dq_data_in), 32'(c_data));
        end else begin
          chk("dq_data_in_idle", 32'(bus.dq_data_in), 32'd0);
        end
        if (bus.rsp_valid === 1'b1) begin
          rsp_cnt++;
          lid.push_back(bus.rsp_id); ldata.push_back(bus.rsp_data);
          lerr.push_back(bus.rsp_err); lcyc.push_back(cyc);
        end
        if (bus.dq_push === 1'b1) begin
          push_cnt++; last_push_cyc = cyc; last_push_data = bus.dq_data_in;
        end
        if (bus.dq_push === 1'b1 && bus.dq_pop === 1'b1) both_cnt++;
        if (rst_n && ((bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready)))
          last_acc_cyc = cyc;
      end
      // state as of the coming rising edge
      if (!rst_n) begin
        started = 1'b1; busy = 1'b0; lg = 1'b1;
        e_sel = 1'b0; e_end = 1'b0; e_rid = 1'b0; e_rdata = 8'h00; e_rerr = 1'b0;
      end else begin
        if (ph == 3) busy = 1'b0;
        if (ph == 2) begin
          if (o_push && o_pop) begin
            if (c_en) mq[mq.size()-1] = c_data; else mq[0] = c_data;
          end else if (o_push) begin
            if (c_en) mq.push_back(c_data); else mq.push_front(c_data);
          end else if (o_pop) begin
            if (c_en) void'(mq.pop_back()); else void'(mq.pop_front());
          end
          if (c_dq) rq1 = mq; else rq0 = mq;
          e_rid = c_who; e_rdata = o_data; e_rerr = o_err;
        end
        if (ga || gb) begin
          busy = 1'b1; tacc = cyc; c_who = gb; lg = gb;
          c_op   = gb ? bus.b_op    : bus.a_op;
          c_dq   = gb ? bus.b_deque : bus.a_deque;
          c_en   = gb ? bus.b_end   : bus.a_end;
          c_data = gb ? bus.b_data  : bus.a_data;
          e_sel = c_dq; e_end = c_en;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit who, input bit [1:0] op, input bit dq, input bit en, input bit [7:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (who) begin
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_deque = dq; bus.b_end = en; bus.b_data = d;
    end else begin
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_deque = dq; bus.a_end = en; bus.a_data = d;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      #2;
      if ((who ? bus.b_ready : bus.a_ready) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept_timeout", 32'(got), 32'd1);
    @(negedge clk);
    if (who) bus.b_valid = 1'b0; else bus.a_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (rsp_cnt < target && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    chk("rsp_timeout", 32'(rsp_cnt >= target), 32'd1);
  endtask

  task automatic do_cmd(input bit who, input bit [1:0] op, input bit dq, input bit en, input bit [7:0] d);
    int t;
    t = rsp_cnt + 1;
    issue(who, op, dq, en, d);
    wait_rsp(t);
  endtask

  int n0, p0, b0;

  initial begin
    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.a_op = 2'b00; bus.a_deque = 1'b0; bus.a_end = 1'b0; bus.a_data = 8'h00;
    bus.b_valid = 1'b0; bus.b_op = 2'b00; bus.b_deque = 1'b0; bus.b_end = 1'b0; bus.b_data = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_dq_select", 32'(bus.dq_select), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A: PUSH deque0 front 0x5A
    do_cmd(1'b0, 2'b01, 1'b0, 1'b0, 8'h5A);
    chk("push_rsp_id", 32'(lid[$]), 32'd0);
    chk("push_rsp_err", 32'(lerr[$]), 32'd0);
    chk("push_rsp_data", 32'(ldata[$]), 32'h00);
    chk("push_strobe_cycle", 32'(last_push_cyc - last_acc_cyc), 32'd2);
    chk("push_strobe_data", 32'(last_push_data), 32'h5A);
    chk("rsp_latency", 32'(lcyc[$] - last_acc_cyc), 32'd3);

    // B: POP deque0 front, then PEEK on the now-empty deque
    do_cmd(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
    chk("pop_rsp_data", 32'(ldata[$]), 32'h5A);
    chk("pop_rsp_err", 32'(lerr[$]), 32'd0);
    chk("pop_rsp_id", 32'(lid[$]), 32'd1);
    do_cmd(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    chk("peek_empty_err", 32'(lerr[$]), 32'd1);
    chk("peek_empty_data", 32'(ldata[$]), 32'h00);

    // A and B both holding requests: A, B, A, B
    n0 = rsp_cnt;
    fork
      begin issue(1'b0, 2'b00, 1'b1, 1'b0, 8'h00); issue(1'b0, 2'b00, 1'b1, 1'b1, 8'h00); end
      begin issue(1'b1, 2'b00, 1'b1, 1'b0, 8'h00); issue(1'b1, 2'b00, 1'b1, 1'b1, 8'h00); end
    join
    wait_rsp(n0 + 4);
    chk("rr_id0", 32'(lid[n0]), 32'd0);
    chk("rr_id1", 32'(lid[n0+1]), 32'd1);
    chk("rr_id2", 32'(lid[n0+2]), 32'd0);
    chk("rr_id3", 32'(lid[n0+3]), 32'd1);
    for (int i = 1; i < 4; i++)
      chk("rr_spacing", 32'(lcyc[n0+i] - lcyc[n0+i-1]), 32'd4);

    // fill deque1 from the back, overflow once, then pop the back
    p0 = push_cnt;
    for (int i = 1; i <= 16; i++) do_cmd(1'b0, 2'b01, 1'b1, 1'b1, 8'(i));
    do_cmd(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF);
    chk("full_push_err", 32'(lerr[$]), 32'd1);
    chk("full_push_data", 32'(ldata[$]), 32'h00);
    chk("fill_push_count", 32'(push_cnt - p0), 32'd16);
    do_cmd(1'b0, 2'b10, 1'b1, 1'b1, 8'h00);
    chk("pop_back_data", 32'(ldata[$]), 32'h10);

    // drain front down to 0x07, then REPLACE it
    for (int i = 1; i <= 6; i++) begin
      do_cmd(1'b0, 2'b10, 1'b1, 1'b0, 8'h00);
      chk("pop_front_seq", 32'(ldata[$]), 32'(i));
    end
    b0 = both_cnt;
    do_cmd(1'b0, 2'b11, 1'b1, 1'b0, 8'h33);
    chk("replace_old_top", 32'(ldata[$]), 32'h07);
    chk("replace_err", 32'(lerr[$]), 32'd0);
    do_cmd(1'b0, 2'b00, 1'b1, 1'b0, 8'h00);
    chk("peek_after_replace", 32'(ldata[$]), 32'h33);
    chk("replace_both_strobes", 32'(both_cnt - b0), 32'd1);

    // reset during SEL of a PUSH drops it
    n0 = rsp_cnt; p0 = push_cnt;
    issue(1'b0, 2'b01, 1'b0, 1'b0, 8'hC3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    chk("dropped_no_rsp", 32'(rsp_cnt), 32'(n0));
    chk("dropped_no_push", 32'(push_cnt), 32'(p0));
    do_cmd(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    chk("peek_after_drop_err", 32'(lerr[$]), 32'd1);

    // randomized traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 99) != 0);
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.a_op    = ($urandom_range(0, 9) < 4) ? 2'b01 : 2'($urandom_range(0, 3));
      bus.a_deque = 1'($urandom_range(0, 1));
      bus.a_end   = 1'($urandom_range(0, 1));
      bus.a_data  = 8'($urandom_range(0, 255));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.b_op    = ($urandom_range(0, 9) < 4) ? 2'b01 : 2'($urandom_range(0, 3));
      bus.b_deque = 1'($urandom_range(0, 1));
      bus.b_end   = 1'($urandom_range(0, 1));
      bus.b_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deque_arbiter.md
# deque_arbiter

Two-requester command arbiter and sequencer in front of the dual-deque datapath (two 8-bit deques at ADDR 0 and ADDR 1, sharing one select/end/push/pop/data bus). It accepts PEEK/PUSH/POP/REPLACE commands from requesters A and B over valid/ready handshakes and grants them round-robin. It sequences each command through the deques' registered-select read timing, checks empty/full, and returns one response per command.

## Interface
- No parameters. Two requesters, 8-bit data and one-bit deque id are fixed.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_valid, b_valid  in  1  command request from requester A / B.
- a_ready, b_ready  out  1  handshake accept; the command transfers when valid and ready are both high.
- a_op, b_op  in  2  command: 00 PEEK, 01 PUSH, 10 POP, 11 REPLACE.
- a_deque, b_deque  in  1  target deque id (0 or 1).
- a_end, b_end  in  1  deque end: 0 front, 1 back.
- a_data, b_data  in  8  write data for PUSH/REPLACE; ignored otherwise.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester that owns the response: 0 A, 1 B.
- rsp_data  out  8  read value (PEEK/POP/REPLACE old top); 0 for PUSH or on error.
- rsp_err  out  1  1 = rejected: PUSH while full, or PEEK/POP/REPLACE while empty.
- dq_select  out  1  shared deque_select to both deques.
- dq_end, dq_push, dq_pop  out  1  shared end_select/push/pop.
- dq_data_in  out  8  shared write data.
- dq0_empty, dq0_full, dq1_empty, dq1_full  in  1  deque status.
- dq0_data_out, dq1_data_out  in  8  deque read ports.

## Operation
- FSM states: IDLE -> SEL -> EXEC -> RESP -> IDLE. Exactly one command is in flight.
- IDLE
  - dq_push and dq_pop are 0.
  - If any requester's valid is high, grant one. If both are high, grant the requester not granted last (last_grant register).
  - Drive the winner's ready high combinationally in the same cycle. The loser's ready stays 0.
  - Latch op, deque, end, data and id; set last_grant to the winner; go to SEL.
- SEL
  - Drive dq_select and dq_end from the latched command, with push = pop = 0. The deques register select/end at this edge.
  - Go to EXEC.
- EXEC
  - The selected deque's data_out is valid in this cycle. Select it by the latched deque id (dqN_data_out, dqN_empty, dqN_full).
  - PEEK: no push/pop. rsp_data = top; err if empty.
  - PUSH: if not full, dq_push = 1 and dq_data_in = data; rsp_data = 0. If full, err and no push.
  - POP: if not empty, dq_pop = 1 and rsp_data = top. If empty, err and no pop.
  - REPLACE: if not empty, dq_push = dq_pop = 1 and dq_data_in = data (the deque overwrites the top in place); rsp_data = old top. If empty, err and no strobes.
  - On any error, rsp_data = 0.
  - Register rsp_data, rsp_err and rsp_id; go to RESP.
- RESP
  - rsp_valid = 1 for exactly this cycle, then go to IDLE.
  - No accept happens in RESP.
- dq_select and dq_end hold their last driven value outside SEL/EXEC. dq_data_in is 0 except in EXEC for PUSH/REPLACE.
- No combinational path from requester inputs to the dq_* outputs. a_ready/b_ready are the only outputs combinational on inputs.

## Timing
- Accept at cycle 0 (IDLE). SEL at cycle 1. Deque strobes at cycle 2 (EXEC), applied at the end of cycle 2. rsp_valid at cycle 3. Next accept no earlier than cycle 4, so throughput is 1 command per 4 cycles.
- A request held across a busy period is accepted in the first IDLE cycle. valid may drop before acceptance without effect.
- Reset values: state IDLE, last_grant = 1 (A wins the first tie), a_ready = b_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, dq_select = 0, dq_end = 0, dq_push = dq_pop = 0, dq_data_in = 0.
- While rst_n is low, dq_push, dq_pop, a_ready and b_ready are forced to 0 combinationally.
- Reset mid-command drops the command: no response, no deque strobe.
- Status is sampled in EXEC. Only this block mutates the deques, so status is stable between SEL and EXEC.

## Test plan
- Reset, then A: PUSH deque0 front 0x5A -> a_ready high in cycle 0; dq_push high in cycle 2 with dq_data_in 0x5A; cycle 3 rsp_valid = 1, rsp_id = 0, rsp_err = 0, rsp_data = 0.
- B: POP deque0 front after the above -> rsp_data 0x5A, rsp_err 0; a following PEEK deque0 -> rsp_err 1, rsp_data 0.
- A and B valid together, both holding requests -> grant order A, B, A, B; responses 4 cycles apart, rsp_id alternating 0, 1, 0, 1.
- PUSH deque1 back 16 times (values 1..16), 17th PUSH 0xFF -> 17th response rsp_err 1 and no dq_push pulse; then POP back -> 16.
- REPLACE deque1 front 0x33 over top 0x07 -> rsp_data 0x07; next PEEK front -> 0x33; dq_push and dq_pop both high in exactly one cycle.
- rst_n low during SEL of a PUSH -> no rsp_valid, no dq_push; after release, a new PEEK on that deque -> rsp_err 1 (deque empty).
